// File: rtl/loader_pkg.sv
// Shared types and stream-format constants for the instruction-memory program loader.
package loader_pkg;
  typedef enum logic [2:0] {IDLE, LEN_HI, LEN_LO, DATA, FINISH} state_e;

  localparam int LEN_BYTES  = 2;
  localparam int WORD_BYTES = 4;
  localparam int LEN_W      = LEN_BYTES * 8;
  localparam int BCNT_W     = $clog2(WORD_BYTES);
endpackage

// File: rtl/byte_word_assembler.sv
// Collects stream bytes MSB-first into 32-bit words; word_valid_o fires on the 4th byte.
module byte_word_assembler
  import loader_pkg::*;
(
  input  logic        clk,
  input  logic        reset,
  input  logic        clear_i,
  input  logic        byte_valid_i,
  input  logic [7:0]  byte_i,
  output logic        word_valid_o,
  output logic [31:0] word_o
);
  // Only the first three bytes need storage; the fourth is taken straight from the input.
  logic [23:0]       shift_q;
  logic [BCNT_W-1:0] cnt_q;

  always_ff @(posedge clk) begin
    if (reset || clear_i) begin
      shift_q <= '0;
      cnt_q   <= '0;
    end else if (byte_valid_i) begin
      shift_q <= {shift_q[15:0], byte_i};
      cnt_q   <= cnt_q + BCNT_W'(1);
    end
  end

  assign word_valid_o = byte_valid_i && (cnt_q == BCNT_W'(WORD_BYTES - 1));
  assign word_o       = {shift_q, byte_i};
endmodule

// File: rtl/imem_program_loader.sv
// Loads a length-prefixed big-endian byte stream into instruction memory while holding the CPU.
module imem_program_loader
  import loader_pkg::*;
#(
  parameter int ADDR_WIDTH = 8
) (
  input  logic                  clk,
  input  logic                  reset,
  input  logic                  start,
  input  logic [7:0]            rx_data,
  input  logic                  rx_valid,
  output logic                  rx_ready,
  output logic                  imem_we,
  output logic [ADDR_WIDTH-1:0] imem_addr,
  output logic [31:0]           imem_wdata,
  output logic                  cpu_hold,
  output logic                  busy,
  output logic                  done,
  output logic                  overflow,
  output logic [15:0]           words_loaded
);
  localparam int DEPTH = 2 ** ADDR_WIDTH;

  state_e            state_q, state_d;
  logic [LEN_W-1:0]  len_q, len_d;
  logic [15:0]       widx_q, widx_d;
  logic              ovf_q, ovf_d;
  logic              we_q, done_q;
  logic [ADDR_WIDTH-1:0] addr_q;
  logic [31:0]       wdata_q;

  logic        xfer, word_valid, in_range;
  logic [31:0] word;

  assign rx_ready = (state_q == LEN_HI) || (state_q == LEN_LO) || (state_q == DATA);
  assign xfer     = rx_valid && rx_ready;
  // Indices past the memory depth are consumed but never written, so the address never wraps.
  assign in_range = ({1'b0, widx_q} < 17'(DEPTH));

  byte_word_assembler u_asm (
    .clk          (clk),
    .reset        (reset),
    .clear_i      (state_q == IDLE),
    .byte_valid_i (xfer && (state_q == DATA)),
    .byte_i       (rx_data),
    .word_valid_o (word_valid),
    .word_o       (word)
  );

  always_comb begin
    state_d = state_q;
    len_d   = len_q;
    widx_d  = widx_q;
    ovf_d   = ovf_q;
    case (state_q)
      IDLE: if (start) begin
        state_d = LEN_HI;
        widx_d  = '0;
        ovf_d   = 1'b0;
      end
      LEN_HI: if (xfer) begin
        len_d[LEN_W-1:8] = rx_data;
        state_d          = LEN_LO;
      end
      LEN_LO: if (xfer) begin
        len_d[7:0] = rx_data;
        state_d    = ({len_q[LEN_W-1:8], rx_data} == '0) ? FINISH : DATA;
      end
      DATA: if (word_valid) begin
        widx_d = widx_q + 16'd1;
        if (!in_range) ovf_d = 1'b1;
        if (widx_q + 16'd1 == len_q) state_d = FINISH;
      end
      FINISH:  state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q <= IDLE;
      len_q   <= '0;
      widx_q  <= '0;
      ovf_q   <= 1'b0;
      we_q    <= 1'b0;
      addr_q  <= '0;
      wdata_q <= '0;
      done_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      len_q   <= len_d;
      widx_q  <= widx_d;
      ovf_q   <= ovf_d;
      we_q    <= word_valid && in_range;
      if (word_valid) begin
        addr_q  <= widx_q[ADDR_WIDTH-1:0];
        wdata_q <= word;
      end
      done_q  <= (state_q == FINISH);
    end
  end

  assign imem_we      = we_q;
  assign imem_addr    = addr_q;
  assign imem_wdata   = wdata_q;
  assign cpu_hold     = (state_q != IDLE);
  assign busy         = (state_q != IDLE);
  assign done         = done_q;
  assign overflow     = ovf_q;
  assign words_loaded = widx_q;
endmodule

// File: tb/tb_imem_program_loader.sv
// Random-stream bench: a 256-word and a 4-word loader share one stream and are checked against a transaction model.
module tb_imem_program_loader;
  logic        clk = 1'b0, reset = 1'b1, start = 1'b0, rx_valid = 1'b0;
  logic [7:0]  rx_data = '0;
  logic        rx_ready[2], imem_we[2], cpu_hold[2], busy[2], done[2], overflow[2];
  logic [15:0] words_loaded[2];
  logic [31:0] imem_wdata[2];
  logic [7:0]  addr0;
  logic [1:0]  addr1;

  int checks = 0, failures = 0, cyc = 0;
  int depth[2] = '{256, 4};
  bit tog = 1'b0;
  logic [31:0] wq[$];

  typedef struct {int d; int cyc; int addr; logic [31:0] data;} ev_t;
  ev_t wr_ev[$];
  ev_t dn_ev[$];
  bit  hold_a[2][8192];
  bit  busy_a[2][8192];

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  imem_program_loader #(.ADDR_WIDTH(8)) u_big (
    .clk(clk), .reset(reset), .start(start), .rx_data(rx_data), .rx_valid(rx_valid),
    .rx_ready(rx_ready[0]), .imem_we(imem_we[0]), .imem_addr(addr0), .imem_wdata(imem_wdata[0]),
    .cpu_hold(cpu_hold[0]), .busy(busy[0]), .done(done[0]), .overflow(overflow[0]),
    .words_loaded(words_loaded[0]));

  imem_program_loader #(.ADDR_WIDTH(2)) u_small (
    .clk(clk), .reset(reset), .start(start), .rx_data(rx_data), .rx_valid(rx_valid),
    .rx_ready(rx_ready[1]), .imem_we(imem_we[1]), .imem_addr(addr1), .imem_wdata(imem_wdata[1]),
    .cpu_hold(cpu_hold[1]), .busy(busy[1]), .done(done[1]), .overflow(overflow[1]),
    .words_loaded(words_loaded[1]));

  always @(negedge clk) begin
    for (int d = 0; d < 2; d++) begin
      if (cyc < 8192) begin
        hold_a[d][cyc] <= (cpu_hold[d] === 1'b1);
        busy_a[d][cyc] <= (busy[d] === 1'b1);
      end
      if (imem_we[d] === 1'b1)
        wr_ev.push_back('{d, cyc, (d == 0) ? int'(addr0) : int'(addr1), imem_wdata[d]});
      if (done[d] === 1'b1)
        dn_ev.push_back('{d, cyc, 0, 32'h0});
    end
  end

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      failures++;
      $display("FAIL %s got=%h exp=%h (cycle %0d)", tag, got, exp, cyc);
    end
  endtask

  task automatic check_idle(input string tag);
    for (int d = 0; d < 2; d++) begin
      chk({tag, "_rx_ready"}, 32'(rx_ready[d]), 0);
      chk({tag, "_we"}, 32'(imem_we[d]), 0);
      chk({tag, "_addr"}, (d == 0) ? 32'(addr0) : 32'(addr1), 0);
      chk({tag, "_wdata"}, imem_wdata[d], 0);
      chk({tag, "_hold"}, 32'(cpu_hold[d]), 0);
      chk({tag, "_busy"}, 32'(busy[d]), 0);
      chk({tag, "_done"}, 32'(done[d]), 0);
      chk({tag, "_overflow"}, 32'(overflow[d]), 0);
      chk({tag, "_words"}, 32'(words_loaded[d]), 0);
    end
  endtask

  // Offers one byte until accepted; md 0=always valid, 1=alternating, 2=random.
  task automatic send_byte(input logic [7:0] b, input int md, input bit pulse_start, output int acc);
    int tries = 0;
    acc = -1;
    rx_data = b;
    if (pulse_start) start = 1'b1;
    while (acc < 0) begin
      case (md)
        0:       rx_valid = 1'b1;
        1:       begin rx_valid = tog; tog = ~tog; end
        default: rx_valid = ($urandom_range(99) < 60);
      endcase
      @(negedge clk);
      if (rx_valid && rx_ready[0]) acc = cyc;
      @(posedge clk); #1;
      start = 1'b0;
      rx_valid = 1'b0;
      tries++;
      if (acc < 0 && tries > 64) begin
        chk("rx_timeout", 0, 1);
        acc = cyc;
      end
    end
  endtask

  task automatic build_bytes(input int n, output logic [7:0] bytes[$]);
    bytes.delete();
    while (wq.size() < n) wq.push_back($urandom);
    bytes.push_back(8'(n >> 8));
    bytes.push_back(8'(n));
    for (int k = 0; k < n; k++)
      for (int j = 3; j >= 0; j--) bytes.push_back(8'(wq[k] >> (8 * j)));
  endtask

  // Full load; returns in the done cycle (after its negedge) so a follow-up start lands in that cycle.
  task automatic do_load(input int n, input int md, input int start_idx);
    int s, L, acc, nexp, got, dcnt, dcyc, hc, bc;
    int acc4[$];
    logic [7:0] bytes[$];
    build_bytes(n, bytes);
    start = 1'b1;
    s = cyc;
    @(posedge clk); #1;
    start = 1'b0;
    L = s;
    for (int i = 0; i < bytes.size(); i++) begin
      send_byte(bytes[i], md, (i == start_idx), acc);
      if (i >= 2 && (i - 2) % 4 == 3) acc4.push_back(acc);
      L = acc;
    end
    @(posedge clk); @(negedge clk); #1;
    for (int d = 0; d < 2; d++) begin
      nexp = (n < depth[d]) ? n : depth[d];
      got = 0;
      foreach (wr_ev[i]) begin
        if (wr_ev[i].d == d && wr_ev[i].cyc > s && wr_ev[i].cyc <= L + 2) begin
          if (got < nexp) begin
            chk("we_addr", wr_ev[i].addr, got);
            chk("we_data", wr_ev[i].data, wq[got]);
            chk("we_cycle", wr_ev[i].cyc, acc4[got] + 1);
          end
          got++;
        end
      end
      chk("we_count", got, nexp);
      dcnt = 0; dcyc = -1;
      foreach (dn_ev[i])
        if (dn_ev[i].d == d && dn_ev[i].cyc > s && dn_ev[i].cyc <= L + 2) begin
          dcnt++; dcyc = dn_ev[i].cyc;
        end
      chk("done_count", dcnt, 1);
      chk("done_cycle", dcyc, L + 2);
      hc = 0; bc = 0;
      for (int c = s + 1; c <= L + 2; c++) begin
        hc += int'(hold_a[d][c]);
        bc += int'(busy_a[d][c]);
      end
      chk("hold_cycles", hc, L + 1 - s);
      chk("busy_cycles", bc, L + 1 - s);
      chk("words_loaded", 32'(words_loaded[d]), n);
      chk("overflow", 32'(overflow[d]), (n > depth[d]) ? 1 : 0);
      chk("rx_ready_idle", 32'(rx_ready[d]), 0);
    end
    wq.delete();
  endtask

  task automatic do_reset_mid();
    int s, acc, got, dcnt;
    logic [7:0] bytes[$];
    build_bytes(2, bytes);
    start = 1'b1;
    s = cyc;
    @(posedge clk); #1;
    start = 1'b0;
    for (int i = 0; i < 8; i++) send_byte(bytes[i], 0, 1'b0, acc);
    reset = 1'b1;
    @(posedge clk); #1;
    reset = 1'b0;
    @(negedge clk);
    check_idle("midreset");
    repeat (4) @(posedge clk);
    @(negedge clk); #1;
    for (int d = 0; d < 2; d++) begin
      got = 0; dcnt = 0;
      foreach (wr_ev[i])
        if (wr_ev[i].d == d && wr_ev[i].cyc > s) begin
          chk("rst_we_addr", wr_ev[i].addr, 0);
          chk("rst_we_data", wr_ev[i].data, wq[0]);
          got++;
        end
      foreach (dn_ev[i]) if (dn_ev[i].d == d && dn_ev[i].cyc > s) dcnt++;
      chk("rst_we_count", got, 1);
      chk("rst_done_count", dcnt, 0);
    end
    wq.delete();
  endtask

  initial begin
    #400000;
    $display("FAIL watchdog expired at cycle %0d", cyc);
    $fatal(1, "watchdog");
  end

  initial begin
    repeat (3) @(posedge clk);
    @(negedge clk);
    check_idle("reset");
    @(posedge clk); #1;
    reset = 1'b0;
    repeat (2) @(posedge clk); #1;

    wq.push_back(32'h12345678);
    wq.push_back(32'h9ABCDEF0);
    do_load(2, 0, -1);
    repeat (2) @(posedge clk); #1;
    do_load(0, 0, -1);
    repeat (2) @(posedge clk); #1;
    do_load(5, 0, -1);
    repeat (3) @(posedge clk); #1;
    do_load(3, 1, -1);
    do_load(2, 2, 7);
    for (int t = 0; t < 8; t++) begin
      repeat ($urandom_range(0, 3)) @(posedge clk);
      #1;
      do_load($urandom_range(0, 9), $urandom_range(0, 2), $urandom_range(0, 30));
    end
    repeat (2) @(posedge clk); #1;
    do_reset_mid();
    do_load(2, 2, 3);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
